// File: rtl/pipe_skid_stage.sv
// Elastic two-entry (main + skid) pipeline stage with valid/ready on both sides and synchronous flush.
// Optional stall statistics counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_stage #(
    parameter int WIDTH       = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // Handshake: a beat moves on a side at a rising edge when valid & ready are both high;
    // valid never depends on ready, and ready depends only on registered state plus flush/reset.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             in_xfer;
    logic             out_xfer;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == SKID);

    assign in_ready  = !skid_valid && !flush && !reset;
    assign out_valid = main_valid && !flush;
    assign out_data  = main_data;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Payload registers are left as-is; only occupancy is squashed.
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state     <= FULL;
                        main_data <= in_data;
                    end
                end
                FULL: begin
                    if (out_xfer && in_xfer) begin
                        main_data <= in_data;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end else if (in_xfer) begin
                        state     <= SKID;
                        skid_data <= in_data;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        state     <= FULL;
                        main_data <= skid_data;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating count of cycles where the consumer is holding off a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
